dram_rd_arbiter: RTL

DRAM_RD_ARBITER -- requirements
Module: dram_rd_arbiter

---
 rtl/dm_readout_pkg.sv | 19 +
 rtl/rd_tag_fifo.sv | 62 ++++++
 rtl/dram_rd_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dm_readout_pkg.sv
// dm_readout_pkg: shared defaults and types for the DRAM read arbiter slice.
//   - default requester count, address/data widths, outstanding-read depth
//   - tag type carrying a requester index through the in-order return FIFO
//   - tag_w(): tag width for a given requester count (never below 1 bit)
package dm_readout_pkg;

   localparam int NUM_REQ_DEF   = 4;
   localparam int ADDR_W_DEF    = 25;
   localparam int DATA_W_DEF    = 256;
   localparam int MAX_OUTST_DEF = 16;
   localparam int TAG_W_DEF     = $clog2(NUM_REQ_DEF);

   typedef logic [TAG_W_DEF-1:0] tag_t;

   function automatic int tag_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// rd_tag_fifo: in-order tag FIFO recording which requester owns each
// outstanding DRAM read.
// Ports:
//   clk, rst_n (sync, active-low)
//   push / din   : enqueue a tag (accepted when not full, or when popping)
//   pop  / dout  : dequeue the head tag; dout is the current head
//   full, empty  : occupancy flags
//   count        : occupancy 0..DEPTH
module rd_tag_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             push_ok, pop_ok;

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign dout  = mem_q[rd_q];

   // A push into a full FIFO is legal when the head leaves in the same
   // cycle: the head is read combinationally before the slot is rewritten.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + PTR_W'(1);
         if (pop_ok)  rd_q <= rd_q + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/dram_rd_arbiter.sv
// dram_rd_arbiter: arbitrates NUM_REQ read requesters onto a single DRAM read
// command port and routes in-order returns back to the owning requester.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_addr  : per-requester read requests (addr slice i*ADDR_W)
//   req_ready           : one-hot grant (combinational)
//   dram_rd_en/addr     : registered command, held until dram_rd_ready
//   dram_rd_ready       : DRAM accepts the command
//   dram_rd_data/valid  : in-order DRAM returns
//   rsp_data/rsp_valid  : registered return data + one-hot owner strobe
//   busy                : command pending or reads outstanding
//   err_unexp           : sticky, a return arrived with nothing outstanding
// Build option: DRAM_RD_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins, no pointer); default build is round-robin.
module dram_rd_arbiter
   import dm_readout_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_OUTST = MAX_OUTST_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      dram_rd_en,
   output logic [ADDR_W-1:0]         dram_rd_addr,
   input  logic                      dram_rd_ready,
   input  logic [DATA_W-1:0]         dram_rd_data,
   input  logic                      dram_rd_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      busy,
   output logic                      err_unexp
);

   localparam int TAG_W = tag_w(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   logic                en_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic [NUM_REQ-1:0]  rsp_valid_q;
   logic                err_q;

   logic [TAG_W-1:0]    head_tag;
   logic                fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_cnt;

   logic                pop, can_issue, grant;
   logic [NUM_REQ-1:0]  sel_vec;
   logic [TAG_W-1:0]    gnt_idx;
   logic                found;
   logic [ADDR_W-1:0]   gnt_addr;

   assign pop = dram_rd_valid && !fifo_empty;

   // A pop in this cycle frees a slot, so a full FIFO may still grant.
   assign can_issue = rst_n && (!en_q || dram_rd_ready) && (!fifo_full || pop);

`ifdef DRAM_RD_ARB_FIXED_PRIO_EN
   always_comb begin
      sel_vec = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i]) begin
            found      = 1'b1;
            gnt_idx    = TAG_W'(i);
            sel_vec[i] = 1'b1;
         end
      end
   end
`else
   logic [TAG_W-1:0] ptr_q;
   int               idx;

   // Scan from the pointer upward, wrapping; ptr_q is the top-priority slot.
   always_comb begin
      sel_vec = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found        = 1'b1;
            gnt_idx      = TAG_W'(idx);
            sel_vec[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr_q <= '0;
      else if (grant)
         ptr_q <= (gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : gnt_idx + TAG_W'(1);
   end
`endif

   assign req_ready = can_issue ? sel_vec : '0;
   assign grant     = can_issue && found;
   assign gnt_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];

   rd_tag_fifo #(
      .DEPTH (MAX_OUTST),
      .W     (TAG_W)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (grant),
      .din   (gnt_idx),
      .pop   (pop),
      .dout  (head_tag),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_q        <= 1'b0;
         addr_q      <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= '0;
         err_q       <= 1'b0;
      end else begin
         // Command register: load on grant, otherwise drop once accepted.
         if (grant) begin
            en_q   <= 1'b1;
            addr_q <= gnt_addr;
         end else if (dram_rd_ready) begin
            en_q   <= 1'b0;
         end

         rsp_valid_q <= pop ? (NUM_REQ'(1) << head_tag) : '0;
         if (pop) rsp_data_q <= dram_rd_data;

         // Returns with no owner are dropped and flagged until reset.
         if (dram_rd_valid && fifo_empty) err_q <= 1'b1;
      end
   end

   assign dram_rd_en   = en_q;
   assign dram_rd_addr = addr_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_valid    = rsp_valid_q;
   assign busy         = en_q || (fifo_cnt != '0);
   assign err_unexp    = err_q;

endmodule
